// File: rtl/sc_pkg.sv
// ----------------------------------------------------------------------------
// sc_pkg
// Shared definitions for the stochastic matrix-multiply controller slice.
//   sc_state_t    : controller sequencing states
//   clog2_min1    : ceiling log2, never smaller than 1 (safe port widths)
//   window_width  : bit width of the loadable window / latency counter
// No ports (package).
// ----------------------------------------------------------------------------
package sc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        LOAD,
        COMPUTE,
        WRITE,
        DONE
    } sc_state_t;

    // Ceiling log2 with a floor of 1 so a single-entry index still gets a bit.
    function automatic int clog2_min1(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

    // Width that holds the largest window SC * 2^BP without overflow.
    function automatic int window_width(input int binary_precision, input int stochastic_cycles);
        int extra;
        extra = (stochastic_cycles > 1) ? clog2_min1(stochastic_cycles) : 0;
        return binary_precision + extra + 1;
    endfunction

endpackage

// File: rtl/sc_window_counter.sv
// ----------------------------------------------------------------------------
// sc_window_counter
// Loadable down-counter with a terminal-count flag. The controller loads it
// with (cycles - 1) on the way into a timed state; tc is high once the count
// reaches zero, marking the last cycle of that state. Counting stops at zero.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   load        : load load_value on the next edge (has priority over counting)
//   load_value  : value to load
//   count       : current count
//   tc          : count == 0
// ----------------------------------------------------------------------------
module sc_window_counter #(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    // Load takes priority; otherwise decrement and park at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/sc_mm_controller.sv
// ----------------------------------------------------------------------------
// sc_mm_controller
// Sequencing FSM for the stochastic matrix-multiply datapath. For every
// (row m, column o) pair, o inner: fetch operands, wait for the memories,
// arm SNGs/RNGs, run the W = STOCHASTIC_CYCLES * 2^BINARY_PRECISION cycle
// window, then write the converted result at m*O+o under out_ready.
// Optional build macro: SC_MM_CTRL_PERF_EN adds perf_busy_cycles and
// perf_stall_cycles (saturating, cleared on rst and on an accepted start).
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   start             : begin a full pass (only honoured in IDLE)
//   busy              : decoded from state, high while a pass is running
//   done              : one-cycle pulse after the last write
//   in_rd_en/in_addr  : input-row memory read strobe / row index m
//   w_rd_en/w_addr    : weight-column memory read strobe / column index o
//   operand_load      : SNGs latch memory read data
//   rng_restart       : LFSRs and select counter reload seeds
//   conv_last         : sd_converter last flag (last window cycle)
//   out_wr_en/out_addr: result write request / address m*O+o
//   out_ready         : output memory accepts the write
// ----------------------------------------------------------------------------
module sc_mm_controller
    import sc_pkg::*;
#(
    parameter int BATCH_SIZE        = 4,
    parameter int INPUT_FEATURES    = 4,
    parameter int OUTPUT_FEATURES   = 4,
    parameter int BINARY_PRECISION  = 8,
    parameter int STOCHASTIC_CYCLES = 1,
    parameter int MEM_LATENCY       = 1
) (
    input  logic                                                  clk,
    input  logic                                                  rst,
    input  logic                                                  start,
    output logic                                                  busy,
    output logic                                                  done,
    output logic                                                  in_rd_en,
    output logic [clog2_min1(BATCH_SIZE)-1:0]                     in_addr,
    output logic                                                  w_rd_en,
    output logic [clog2_min1(OUTPUT_FEATURES)-1:0]                w_addr,
    output logic                                                  operand_load,
    output logic                                                  rng_restart,
    output logic                                                  conv_last,
    output logic                                                  out_wr_en,
    output logic [clog2_min1(BATCH_SIZE*OUTPUT_FEATURES)-1:0]     out_addr,
    input  logic                                                  out_ready
`ifdef SC_MM_CTRL_PERF_EN
    ,
    output logic [31:0]                                           perf_busy_cycles,
    output logic [31:0]                                           perf_stall_cycles
`endif
);

    localparam int M_W   = clog2_min1(BATCH_SIZE);
    localparam int O_W   = clog2_min1(OUTPUT_FEATURES);
    localparam int OUT_W = clog2_min1(BATCH_SIZE * OUTPUT_FEATURES);
    localparam int WIN_W = window_width(BINARY_PRECISION, STOCHASTIC_CYCLES);
    localparam int unsigned WINDOW_CYCLES = STOCHASTIC_CYCLES * (1 << BINARY_PRECISION);

    localparam logic [M_W-1:0]   LAST_M   = M_W'(BATCH_SIZE - 1);
    localparam logic [O_W-1:0]   LAST_O   = O_W'(OUTPUT_FEATURES - 1);
    localparam logic [WIN_W-1:0] WIN_LOAD = WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [WIN_W-1:0] LAT_LOAD = WIN_W'(MEM_LATENCY - 1);

    // Elaboration-time guard on parameter ranges and counter width.
    generate
        if (BATCH_SIZE < 1 || OUTPUT_FEATURES < 1 || INPUT_FEATURES < 1 ||
            MEM_LATENCY < 1 || STOCHASTIC_CYCLES < 1) begin : g_bad_params
            $error("sc_mm_controller: parameter out of range");
        end
        if ((MEM_LATENCY - 1) >= (1 << WIN_W)) begin : g_latency_too_wide
            $error("sc_mm_controller: MEM_LATENCY does not fit the window counter");
        end
    endgenerate

    sc_state_t        state;
    sc_state_t        next_state;
    logic             cnt_load;
    logic [WIN_W-1:0] cnt_load_value;
    logic [WIN_W-1:0] cnt_count;
    logic             cnt_tc;
    logic             conv_last_next;
    logic             last_pair;

    // One counter times both WAIT (memory latency) and COMPUTE (window).
    sc_window_counter #(
        .WIDTH(WIN_W)
    ) u_window_counter (
        .clk       (clk),
        .rst       (rst),
        .load      (cnt_load),
        .load_value(cnt_load_value),
        .count     (cnt_count),
        .tc        (cnt_tc)
    );

    assign last_pair = (in_addr == LAST_M) && (w_addr == LAST_O);
    assign busy      = (state != IDLE) && (state != DONE);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. The counter is loaded in the cycle before each timed
    // state so it reads (cycles - 1) on that state's first cycle. conv_last is
    // predicted one cycle ahead because it is registered.
    always_comb begin
        next_state     = state;
        cnt_load       = 1'b0;
        cnt_load_value = WIN_LOAD;
        conv_last_next = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    next_state = FETCH;
                end
            end
            FETCH: begin
                next_state     = WAIT;
                cnt_load       = 1'b1;
                cnt_load_value = LAT_LOAD;
            end
            WAIT: begin
                if (cnt_tc) begin
                    next_state = LOAD;
                end
            end
            LOAD: begin
                next_state     = COMPUTE;
                cnt_load       = 1'b1;
                cnt_load_value = WIN_LOAD;
                conv_last_next = (WINDOW_CYCLES == 1);
            end
            COMPUTE: begin
                if (cnt_tc) begin
                    next_state = WRITE;
                end
                conv_last_next = (cnt_count == WIN_W'(1));
            end
            WRITE: begin
                if (out_ready) begin
                    next_state = last_pair ? DONE : FETCH;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Strobes are registered from next_state so they line up with the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_rd_en     <= 1'b0;
            w_rd_en      <= 1'b0;
            operand_load <= 1'b0;
            rng_restart  <= 1'b0;
            conv_last    <= 1'b0;
            out_wr_en    <= 1'b0;
            done         <= 1'b0;
        end else begin
            in_rd_en     <= (next_state == FETCH);
            w_rd_en      <= (next_state == FETCH);
            operand_load <= (next_state == LOAD);
            rng_restart  <= (next_state == LOAD);
            conv_last    <= conv_last_next;
            out_wr_en    <= (next_state == WRITE);
            done         <= (next_state == DONE);
        end
    end

    // Indices advance only on an accepted non-final write; out_addr steps
    // linearly because o is the inner loop, so it always equals m*O+o.
    always_ff @(posedge clk) begin
        if (rst || state == IDLE) begin
            in_addr  <= '0;
            w_addr   <= '0;
            out_addr <= '0;
        end else if (state == WRITE && out_ready && !last_pair) begin
            out_addr <= out_addr + OUT_W'(1);
            if (w_addr == LAST_O) begin
                w_addr  <= '0;
                in_addr <= in_addr + M_W'(1);
            end else begin
                w_addr <= w_addr + O_W'(1);
            end
        end
    end

`ifdef SC_MM_CTRL_PERF_EN
    // Saturating performance counters; they naturally hold while idle.
    always_ff @(posedge clk) begin
        if (rst || (state == IDLE && start)) begin
            perf_busy_cycles  <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (busy && perf_busy_cycles != '1) begin
                perf_busy_cycles <= perf_busy_cycles + 32'd1;
            end
            if (state == WRITE && !out_ready && perf_stall_cycles != '1) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sc_mm_controller.sv
// ----------------------------------------------------------------------------
// tb_sc_mm_controller
// Three controller configurations share one clock, reset and out_ready:
//   inst 0: defaults (M=4, O=4, BP=8, SC=1, LAT=1)
//   inst 1: M=2, O=3, BP=8, SC=3, LAT=2
//   inst 2: M=1, O=1, BP=2, SC=1, LAT=1
// Only one instance runs a pass at a time. applyStimulus pushes the expected
// writes and done timing into queues; a negedge monitor (checkOutput) pops
// and compares whenever an instance presents a write or done.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sc_mm_controller;

    localparam int M_OF[3]   = '{4, 2, 1};
    localparam int O_OF[3]   = '{4, 3, 1};
    localparam int LAT_OF[3] = '{1, 2, 1};
    localparam int WIN_OF[3] = '{1 * 256, 3 * 256, 1 * 4};

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       in_rd_en;
        logic       w_rd_en;
        logic       operand_load;
        logic       rng_restart;
        logic       conv_last;
        logic       out_wr_en;
        logic [7:0] in_addr;
        logic [7:0] w_addr;
        logic [7:0] out_addr;
    } smp_t;

    typedef struct {
        int inst;
        int addr;
        int m;
        int o;
        int rise;
        int stall;
    } wr_exp_t;

    typedef struct {
        int inst;
        int lbl;
        int busy;
        int stalls;
        int writes;
    } done_exp_t;

    logic clk = 1'b0;
    logic rst;
    logic out_ready;
    logic start0, start1, start2;

    logic       busy0, done0, in_rd0, w_rd0, ld0, rr0, cl0, wr0;
    logic [1:0] in_addr0, w_addr0;
    logic [3:0] out_addr0;
    logic       busy1, done1, in_rd1, w_rd1, ld1, rr1, cl1, wr1;
    logic [0:0] in_addr1;
    logic [1:0] w_addr1;
    logic [2:0] out_addr1;
    logic       busy2, done2, in_rd2, w_rd2, ld2, rr2, cl2, wr2;
    logic [0:0] in_addr2, w_addr2, out_addr2;

    smp_t smp[3];

    int cyc = 0;
    int checks = 0;
    int failures = 0;
    int act = 0;
    bit mon_en = 0;
    int writes_seen = 0;
    int done_seen = 0;

    wr_exp_t   exp_q[$];
    done_exp_t done_q[$];
    int        stall_q[$];

    wr_exp_t cur[3];
    bit      in_wr[3];
    int      hold_start[3];
    int      fetch_lbl[3];
    int      load_lbl[3];
    int      busy_cnt[3];
    int      conv_cnt[3];

    bit drv_active = 0;
    int drv_left = 0;

    always #5 clk = ~clk;

`ifdef SC_MM_CTRL_PERF_EN
    logic [31:0] pb0, ps0, pb1, ps1, pb2, ps2;
    logic [31:0] perf_b[3];
    logic [31:0] perf_s[3];
    assign perf_b[0] = pb0;
    assign perf_b[1] = pb1;
    assign perf_b[2] = pb2;
    assign perf_s[0] = ps0;
    assign perf_s[1] = ps1;
    assign perf_s[2] = ps2;
`endif

    sc_mm_controller #(
        .BATCH_SIZE(4), .INPUT_FEATURES(4), .OUTPUT_FEATURES(4),
        .BINARY_PRECISION(8), .STOCHASTIC_CYCLES(1), .MEM_LATENCY(1)
    ) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .busy(busy0), .done(done0),
        .in_rd_en(in_rd0), .in_addr(in_addr0), .w_rd_en(w_rd0), .w_addr(w_addr0),
        .operand_load(ld0), .rng_restart(rr0), .conv_last(cl0),
        .out_wr_en(wr0), .out_addr(out_addr0), .out_ready(out_ready)
`ifdef SC_MM_CTRL_PERF_EN
        , .perf_busy_cycles(pb0), .perf_stall_cycles(ps0)
`endif
    );

    sc_mm_controller #(
        .BATCH_SIZE(2), .INPUT_FEATURES(4), .OUTPUT_FEATURES(3),
        .BINARY_PRECISION(8), .STOCHASTIC_CYCLES(3), .MEM_LATENCY(2)
    ) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
        .in_rd_en(in_rd1), .in_addr(in_addr1), .w_rd_en(w_rd1), .w_addr(w_addr1),
        .operand_load(ld1), .rng_restart(rr1), .conv_last(cl1),
        .out_wr_en(wr1), .out_addr(out_addr1), .out_ready(out_ready)
`ifdef SC_MM_CTRL_PERF_EN
        , .perf_busy_cycles(pb1), .perf_stall_cycles(ps1)
`endif
    );

    sc_mm_controller #(
        .BATCH_SIZE(1), .INPUT_FEATURES(4), .OUTPUT_FEATURES(1),
        .BINARY_PRECISION(2), .STOCHASTIC_CYCLES(1), .MEM_LATENCY(1)
    ) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2),
        .in_rd_en(in_rd2), .in_addr(in_addr2), .w_rd_en(w_rd2), .w_addr(w_addr2),
        .operand_load(ld2), .rng_restart(rr2), .conv_last(cl2),
        .out_wr_en(wr2), .out_addr(out_addr2), .out_ready(out_ready)
`ifdef SC_MM_CTRL_PERF_EN
        , .perf_busy_cycles(pb2), .perf_stall_cycles(ps2)
`endif
    );

    assign smp[0] = {busy0, done0, in_rd0, w_rd0, ld0, rr0, cl0, wr0,
                     8'(in_addr0), 8'(w_addr0), 8'(out_addr0)};
    assign smp[1] = {busy1, done1, in_rd1, w_rd1, ld1, rr1, cl1, wr1,
                     8'(in_addr1), 8'(w_addr1), 8'(out_addr1)};
    assign smp[2] = {busy2, done2, in_rd2, w_rd2, ld2, rr2, cl2, wr2,
                     8'(in_addr2), 8'(w_addr2), 8'(out_addr2)};

    // Cycle label: number of rising edges so far.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic chk(input string name, input longint act_v, input longint req_v);
        checks++;
        if (act_v != req_v) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d required=%0d (cycle %0d)", name, act_v, req_v, cyc);
        end
    endtask

    task automatic setStart(input int inst, input logic val);
        case (inst)
            0: start0 = val;
            1: start1 = val;
            default: start2 = val;
        endcase
    endtask

    task automatic flushModel();
        exp_q.delete();
        done_q.delete();
        stall_q.delete();
        drv_active = 0;
        drv_left = 0;
        for (int i = 0; i < 3; i++) begin
            in_wr[i] = 0;
            busy_cnt[i] = 0;
            conv_cnt[i] = 0;
        end
    endtask

    // Builds the expected pass from the element cost 3+LAT+W plus the stalls
    // the driver will insert, then pulses start for one cycle.
    task automatic applyStimulus(input int inst, input int stall_idx, input int stall_val);
        int n, t, total_stall, elems, cost;
        wr_exp_t e;
        done_exp_t d;
        @(posedge clk);
        #1;
        n = cyc;
        elems = M_OF[inst] * O_OF[inst];
        cost = 3 + LAT_OF[inst] + WIN_OF[inst];
        t = n;
        total_stall = 0;
        for (int k = 0; k < elems; k++) begin
            e.inst  = inst;
            e.addr  = k;
            e.m     = k / O_OF[inst];
            e.o     = k % O_OF[inst];
            e.stall = (k == stall_idx) ? stall_val : int'($urandom_range(0, 3));
            e.rise  = t + cost;
            t = e.rise + e.stall;
            total_stall += e.stall;
            exp_q.push_back(e);
            stall_q.push_back(e.stall);
        end
        d.inst   = inst;
        d.lbl    = t + 1;
        d.busy   = t - n;
        d.stalls = total_stall;
        d.writes = elems;
        done_q.push_back(d);
        act = inst;
        setStart(inst, 1'b1);
        @(posedge clk);
        #1;
        setStart(inst, 1'b0);
    endtask

    task automatic checkOutput(input int i, input smp_t s);
        done_exp_t d;
        int left;
        if (s.in_rd_en) begin
            chk("fetch_w_rd_en", s.w_rd_en, 1);
            fetch_lbl[i] = cyc;
        end
        if (s.operand_load) begin
            chk("fetch_to_load_gap", cyc - fetch_lbl[i], LAT_OF[i] + 1);
            chk("load_rng_restart", s.rng_restart, 1);
            load_lbl[i] = cyc;
        end
        if (s.conv_last) begin
            chk("load_to_conv_last_gap", cyc - load_lbl[i], WIN_OF[i]);
            conv_cnt[i]++;
        end
        if (s.busy) begin
            busy_cnt[i]++;
        end
        if (s.out_wr_en) begin
            if (!in_wr[i]) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write_inst", i, -1);
                end else begin
                    cur[i] = exp_q.pop_front();
                    chk("write_inst", i, cur[i].inst);
                    chk("write_rise_cycle", cyc, cur[i].rise);
                end
                in_wr[i] = 1;
                hold_start[i] = cyc;
            end
            chk("write_out_addr", s.out_addr, cur[i].addr);
            chk("write_in_addr", s.in_addr, cur[i].m);
            chk("write_w_addr", s.w_addr, cur[i].o);
            if (out_ready) begin
                chk("write_hold_cycles", cyc - hold_start[i] + 1, cur[i].stall + 1);
                in_wr[i] = 0;
                writes_seen++;
            end
        end else if (in_wr[i]) begin
            chk("write_dropped_before_ready", 0, 1);
            in_wr[i] = 0;
        end
        if (s.done) begin
            done_seen++;
            if (done_q.size() == 0) begin
                chk("unexpected_done_inst", i, -1);
            end else begin
                d = done_q.pop_front();
                left = 0;
                foreach (exp_q[k]) begin
                    if (exp_q[k].inst == i) left++;
                end
                chk("done_inst", i, d.inst);
                chk("done_cycle", cyc, d.lbl);
                chk("busy_cycles", busy_cnt[i], d.busy);
                chk("conv_last_count", conv_cnt[i], d.writes);
                chk("writes_outstanding", left, 0);
`ifdef SC_MM_CTRL_PERF_EN
                chk("perf_busy_cycles", perf_b[i], d.busy);
                chk("perf_stall_cycles", perf_s[i], d.stalls);
`endif
            end
            busy_cnt[i] = 0;
            conv_cnt[i] = 0;
        end
    endtask

    // Monitor: samples all instances on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                for (int i = 0; i < 3; i++) begin
                    checkOutput(i, smp[i]);
                end
            end
        end
    end

    // out_ready driver: planned stalls during WRITE of the active instance,
    // random noise elsewhere (must be ignored by the design).
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (smp[act].out_wr_en) begin
                if (!drv_active) begin
                    drv_active = 1;
                    drv_left = 0;
                    if (stall_q.size() > 0) drv_left = stall_q.pop_front();
                end
                if (drv_left > 0) begin
                    out_ready = 1'b0;
                    drv_left--;
                end else begin
                    out_ready = 1'b1;
                    drv_active = 0;
                end
            end else begin
                out_ready = 1'($urandom_range(0, 1));
                drv_active = 0;
            end
        end
    end

    task automatic waitPassEnd(input int budget);
        int k;
        k = 0;
        while (done_q.size() != 0 && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (done_q.size() != 0) begin
            chk("pass_timeout_pending_done", done_q.size(), 0);
            flushModel();
        end
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic waitWrites(input int n, input int budget);
        int k;
        k = 0;
        while (writes_seen < n && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (writes_seen < n) begin
            chk("write_wait_timeout", writes_seen, n);
        end
    endtask

    initial begin
        rst = 1'b1;
        start0 = 1'b0;
        start1 = 1'b0;
        start2 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_wr[i] = 0; hold_start[i] = 0; fetch_lbl[i] = 0;
            load_lbl[i] = 0; busy_cnt[i] = 0; conv_cnt[i] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("reset_outputs_zero", smp[i], 0);
`ifdef SC_MM_CTRL_PERF_EN
            chk("reset_perf_busy", perf_b[i], 0);
            chk("reset_perf_stall", perf_s[i], 0);
`endif
        end
        rst = 1'b0;
        mon_en = 1;

        $display("[TB] pass 1: defaults, 5-cycle stall at element 3, start re-asserted at element 7");
        writes_seen = 0;
        done_seen = 0;
        applyStimulus(0, 3, 5);
        waitWrites(7, 3000);
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        waitPassEnd(6000);
        repeat (20) @(posedge clk);
        #1;
        chk("pass1_done_pulses", done_seen, 1);

        $display("[TB] pass 2: reset during COMPUTE of element 9");
        writes_seen = 0;
        done_seen = 0;
        applyStimulus(0, -1, 0);
        waitWrites(9, 4000);
        repeat ($urandom_range(4, 200)) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        flushModel();
        chk("abort_outputs_zero", smp[0], 0);
        chk("abort_busy", smp[0].busy, 0);
`ifdef SC_MM_CTRL_PERF_EN
        chk("abort_perf_busy", perf_b[0], 0);
        chk("abort_perf_stall", perf_s[0], 0);
`endif
        repeat (300) @(posedge clk);
        #1;
        chk("abort_no_done", done_seen, 0);

        $display("[TB] pass 3: fresh pass after abort");
        writes_seen = 0;
        applyStimulus(0, -1, 0);
        waitPassEnd(6000);

        $display("[TB] pass 4: M=2 O=3 SC=3 LAT=2");
        applyStimulus(1, -1, 0);
        waitPassEnd(7000);

        $display("[TB] pass 5: M=O=1 BP=2");
        applyStimulus(2, 0, 0);
        waitPassEnd(100);

        mon_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
